lc3_control_unit: RTL and testbench

Parametrised successor to the LC-3 instruction sequencer. It fetches, decodes and executes the full load/store/branch subset: ADD, AND, NOT, BR, JMP/RET, JSR/JSRR, LEA, LD, LDR, LDI, ST, STR and STI. Memory access length is set by parameter and can optionally be stretched by a `Mem_Ready` handshake. It drives the same datapath control bus as the previous sequencer, sitting between the IR/BEN logic and the register file, ALU, bus gates and SRAM controls.

---
 rtl/lc3_ctrl_pkg.sv | 58 +++++
 rtl/lc3_control_unit_mem_wait_ctr.sv | 31 +++
 rtl/lc3_control_unit.sv | 169 ++++++++++++++++
 tb/tb_lc3_control_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control unit: state set, return tags,
// opcodes and the datapath mux encodings.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH, S_RD, S_IR, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP,
    S_JSR_LINK, S_JSR_PC11, S_JSRR_PC, S_LEA,
    S_ADDR_PC, S_ADDR_REG, S_LDI_MAR, S_LD_WB,
    S_STI_MAR, S_ST_DATA, S_WR, S_PAUSE1, S_PAUSE2
  } state_t;

  // Where a shared read sequence hands control back to
  typedef enum logic [1:0] {
    RET_IR      = 2'd0,
    RET_LDI_MAR = 2'd1,
    RET_LD_WB   = 2'd2,
    RET_STI_MAR = 2'd3
  } ret_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] PCMUX_PC1    = 2'b00;
  localparam logic [1:0] PCMUX_ADDER  = 2'b01;
  localparam logic [1:0] PCMUX_BUS    = 2'b10;
  localparam logic [1:0] ADDR2_OFF11  = 2'b00;
  localparam logic [1:0] ADDR2_OFF9   = 2'b01;
  localparam logic [1:0] ADDR2_OFF6   = 2'b10;
  localparam logic [1:0] ADDR2_ZERO   = 2'b11;
  localparam logic       ADDR1_SR1    = 1'b0;
  localparam logic       ADDR1_PC     = 1'b1;
  localparam logic [1:0] SR1_IR11_9   = 2'b00;
  localparam logic [1:0] SR1_IR8_6    = 2'b01;
  localparam logic [1:0] DR_IR11_9    = 2'b00;
  localparam logic [1:0] DR_R7        = 2'b10;
  localparam logic [1:0] ALUK_ADD     = 2'b00;
  localparam logic [1:0] ALUK_AND     = 2'b01;
  localparam logic [1:0] ALUK_NOT     = 2'b10;
  localparam logic [1:0] ALUK_PASSA   = 2'b11;
  localparam logic       MARMUX_ADDER = 1'b1;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_RD) || (s == S_WR);
  endfunction

endpackage

// File: rtl/lc3_control_unit_mem_wait_ctr.sv
// Memory access length counter: loaded on entry to a read/write, counts down,
// and reports completion once the minimum has elapsed (and the SRAM is ready).
module mem_wait_ctr #(
  parameter int USE_READY = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       mem_ready,
  output logic       done
);

  localparam logic USE_READY_L = (USE_READY != 0);

  logic [3:0] cnt_r;

  // Down-counter, parked at zero between accesses
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != 4'd0) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  assign done = (cnt_r == 4'd0) && (!USE_READY_L || mem_ready);

endmodule

// File: rtl/lc3_control_unit.sv
// LC-3 instruction sequencer: Moore FSM driving the datapath control bus and
// active-low SRAM strobes, with parametrised read/write access lengths.
module lc3_control_unit
  import lc3_ctrl_pkg::*;
#(
  parameter int RD_WAIT   = 1,
  parameter int WR_CYCLES = 2,
  parameter int USE_READY = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       Mem_Ready,
  output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  output logic       GatePC, GateMDR, GateALU, GateMARMUX,
  output logic [1:0] PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK,
  output logic       SR2MUX, ADDR1MUX, MARMUX,
  output logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
  output logic       Busy
);

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT);
  localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

  state_t     state_r, state_nxt_s;
  ret_t       ret_r, ret_nxt_s;
  logic       done_s, ctr_load_s;
  logic [3:0] ctr_val_s;

  mem_wait_ctr #(.USE_READY(USE_READY)) u_ctr (
    .Clk(Clk), .Reset_n(Reset_n), .load(ctr_load_s), .load_val(ctr_val_s),
    .mem_ready(Mem_Ready), .done(done_s)
  );

  // State and read-return tag registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= S_HALTED;
      ret_r   <= RET_IR;
    end else begin
      state_r <= state_nxt_s;
      ret_r   <= ret_nxt_s;
    end
  end

  // Next-state and return-tag selection
  always_comb begin
    state_nxt_s = state_r;
    ret_nxt_s   = ret_r;
    case (state_r)
      S_HALTED: if (Run) state_nxt_s = S_FETCH; else state_nxt_s = S_HALTED;
      S_FETCH: begin state_nxt_s = S_RD; ret_nxt_s = RET_IR; end
      S_RD: begin
        if (done_s) begin
          case (ret_r)
            RET_IR:      state_nxt_s = S_IR;
            RET_LDI_MAR: state_nxt_s = S_LDI_MAR;
            RET_LD_WB:   state_nxt_s = S_LD_WB;
            RET_STI_MAR: state_nxt_s = S_STI_MAR;
            default:     state_nxt_s = S_HALTED;
          endcase
        end else begin
          state_nxt_s = S_RD;
        end
      end
      S_IR: state_nxt_s = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD: state_nxt_s = S_ADD;
          OP_AND: state_nxt_s = S_AND;
          OP_NOT: state_nxt_s = S_NOT;
          OP_BR:  if (BEN) state_nxt_s = S_BR_TAKE; else state_nxt_s = S_FETCH;
          OP_JMP: state_nxt_s = S_JMP;
          OP_JSR: state_nxt_s = S_JSR_LINK;
          OP_LEA: state_nxt_s = S_LEA;
          OP_LD, OP_LDI, OP_ST, OP_STI: state_nxt_s = S_ADDR_PC;
          OP_LDR, OP_STR:               state_nxt_s = S_ADDR_REG;
          default: state_nxt_s = S_PAUSE1;
        endcase
      end
      S_ADDR_PC, S_ADDR_REG: begin
        case (Opcode)
          OP_LD, OP_LDR: begin state_nxt_s = S_RD; ret_nxt_s = RET_LD_WB; end
          OP_LDI:        begin state_nxt_s = S_RD; ret_nxt_s = RET_LDI_MAR; end
          OP_STI:        begin state_nxt_s = S_RD; ret_nxt_s = RET_STI_MAR; end
          OP_ST, OP_STR: state_nxt_s = S_ST_DATA;
          default:       state_nxt_s = S_FETCH;
        endcase
      end
      S_LDI_MAR:  begin state_nxt_s = S_RD; ret_nxt_s = RET_LD_WB; end
      S_STI_MAR:  state_nxt_s = S_ST_DATA;
      S_ST_DATA:  state_nxt_s = S_WR;
      S_WR:       if (done_s) state_nxt_s = S_FETCH; else state_nxt_s = S_WR;
      S_JSR_LINK: if (IR_11) state_nxt_s = S_JSR_PC11; else state_nxt_s = S_JSRR_PC;
      S_PAUSE1:   if (Continue) state_nxt_s = S_PAUSE2; else state_nxt_s = S_PAUSE1;
      S_PAUSE2:   if (!Continue) state_nxt_s = S_FETCH; else state_nxt_s = S_PAUSE2;
      S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_JSR_PC11, S_JSRR_PC, S_LEA, S_LD_WB:
        state_nxt_s = S_FETCH;
      default: state_nxt_s = S_HALTED;
    endcase
  end

  // Counter is primed only on the transition into a memory state
  always_comb begin
    ctr_load_s = 1'b0;
    ctr_val_s  = RD_LOAD;
    if (is_mem_state(state_nxt_s) && (state_nxt_s != state_r)) begin
      ctr_load_s = 1'b1;
      if (state_nxt_s == S_WR) ctr_val_s = WR_LOAD; else ctr_val_s = RD_LOAD;
    end else begin
      ctr_load_s = 1'b0;
    end
  end

  // Control bus decode from the current state
  always_comb begin
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = 8'd0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = 4'd0;
    {PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK} = 10'd0;
    {SR2MUX, ADDR1MUX, MARMUX} = 3'd0;
    {Mem_CE, Mem_UB, Mem_LB} = 3'd0;
    Mem_OE = 1'b1;
    Mem_WE = 1'b1;
    Busy   = (state_r != S_HALTED);
    case (state_r)
      S_FETCH:  begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_PC1; end
      S_RD:     begin Mem_OE = 1'b0; LD_MDR = done_s; end
      S_IR:     begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        SR1MUX = SR1_IR8_6; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        if (state_r == S_NOT) ALUK = ALUK_NOT;
        else if (state_r == S_AND) begin ALUK = ALUK_AND; SR2MUX = IR_5; end
        else begin ALUK = ALUK_ADD; SR2MUX = IR_5; end
      end
      S_BR_TAKE: begin ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_JMP, S_JSRR_PC: begin
        SR1MUX = SR1_IR8_6; ADDR1MUX = ADDR1_SR1; ADDR2MUX = ADDR2_ZERO;
        PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
      end
      S_JSR_LINK: begin GatePC = 1'b1; DRMUX = DR_R7; LD_REG = 1'b1; end
      S_JSR_PC11: begin ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_OFF11; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_LEA: begin
        ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_OFF9; MARMUX = MARMUX_ADDER;
        GateMARMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S_ADDR_PC: begin
        ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_OFF9; MARMUX = MARMUX_ADDER;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_ADDR_REG: begin
        SR1MUX = SR1_IR8_6; ADDR1MUX = ADDR1_SR1; ADDR2MUX = ADDR2_OFF6;
        MARMUX = MARMUX_ADDER; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_LDI_MAR, S_STI_MAR: begin GateMDR = 1'b1; LD_MAR = 1'b1; end
      S_LD_WB:   begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_ST_DATA: begin SR1MUX = SR1_IR11_9; ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1; end
      S_WR:      begin Mem_WE = 1'b0; GateMDR = 1'b1; end
      S_PAUSE1, S_PAUSE2: LD_LED = 1'b1;
      default: Busy = (state_r != S_HALTED);
    endcase
  end

endmodule

// File: tb/tb_lc3_control_unit.sv
// Bench for lc3_control_unit: two instances (default timing, and slow memory
// with ready handshake) checked cycle by cycle against a micro-step model.
module tb_lc3_control_unit;

  localparam int P_LDMAR = 0, P_LDMDR = 1, P_LDIR = 2, P_LDBEN = 3, P_LDCC = 4;
  localparam int P_LDREG = 5, P_LDPC = 6, P_LDLED = 7, P_GPC = 8, P_GMDR = 9;
  localparam int P_GALU = 10, P_GMARMUX = 11, P_PCMUX = 12, P_DRMUX = 14;
  localparam int P_SR1 = 16, P_ADDR2 = 18, P_ALUK = 20, P_SR2 = 22, P_ADDR1 = 23;
  localparam int P_MARMUX = 24, P_OE = 28, P_WE = 29, P_BUSY = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n_v, run_v, cont_v, ir5_v, ir11_v, ben_v, rdy_v;
  logic [3:0]  op_a, op_b;
  logic [30:0] cw_a, cw_b;
  int total = 0;
  int bad = 0;

  typedef struct { logic [30:0] w; bit rdy; bit cont; bit run; string nm; } cyc_t;
  typedef struct { logic [3:0] op; bit ir5; bit ir11; bit ben; int len; string nm; } vec_t;
  cyc_t q[$];
  vec_t tbl[15];

  lc3_control_unit #(.RD_WAIT(1), .WR_CYCLES(2), .USE_READY(0)) dut_a (
    .Clk(clk), .Reset_n(rst_n_v[0]), .Run(run_v[0]), .Continue(cont_v[0]), .Opcode(op_a),
    .IR_5(ir5_v[0]), .IR_11(ir11_v[0]), .BEN(ben_v[0]), .Mem_Ready(rdy_v[0]),
    .LD_MAR(cw_a[0]), .LD_MDR(cw_a[1]), .LD_IR(cw_a[2]), .LD_BEN(cw_a[3]), .LD_CC(cw_a[4]),
    .LD_REG(cw_a[5]), .LD_PC(cw_a[6]), .LD_LED(cw_a[7]), .GatePC(cw_a[8]), .GateMDR(cw_a[9]),
    .GateALU(cw_a[10]), .GateMARMUX(cw_a[11]), .PCMUX(cw_a[13:12]), .DRMUX(cw_a[15:14]),
    .SR1MUX(cw_a[17:16]), .ADDR2MUX(cw_a[19:18]), .ALUK(cw_a[21:20]), .SR2MUX(cw_a[22]),
    .ADDR1MUX(cw_a[23]), .MARMUX(cw_a[24]), .Mem_CE(cw_a[25]), .Mem_UB(cw_a[26]),
    .Mem_LB(cw_a[27]), .Mem_OE(cw_a[28]), .Mem_WE(cw_a[29]), .Busy(cw_a[30]));

  lc3_control_unit #(.RD_WAIT(3), .WR_CYCLES(3), .USE_READY(1)) dut_b (
    .Clk(clk), .Reset_n(rst_n_v[1]), .Run(run_v[1]), .Continue(cont_v[1]), .Opcode(op_b),
    .IR_5(ir5_v[1]), .IR_11(ir11_v[1]), .BEN(ben_v[1]), .Mem_Ready(rdy_v[1]),
    .LD_MAR(cw_b[0]), .LD_MDR(cw_b[1]), .LD_IR(cw_b[2]), .LD_BEN(cw_b[3]), .LD_CC(cw_b[4]),
    .LD_REG(cw_b[5]), .LD_PC(cw_b[6]), .LD_LED(cw_b[7]), .GatePC(cw_b[8]), .GateMDR(cw_b[9]),
    .GateALU(cw_b[10]), .GateMARMUX(cw_b[11]), .PCMUX(cw_b[13:12]), .DRMUX(cw_b[15:14]),
    .SR1MUX(cw_b[17:16]), .ADDR2MUX(cw_b[19:18]), .ALUK(cw_b[21:20]), .SR2MUX(cw_b[22]),
    .ADDR1MUX(cw_b[23]), .MARMUX(cw_b[24]), .Mem_CE(cw_b[25]), .Mem_UB(cw_b[26]),
    .Mem_LB(cw_b[27]), .Mem_OE(cw_b[28]), .Mem_WE(cw_b[29]), .Busy(cw_b[30]));

  function automatic int rdw(input int d); return (d == 0) ? 1 : 3; endfunction
  function automatic int wrc(input int d); return (d == 0) ? 2 : 3; endfunction
  function automatic bit usr(input int d); return (d != 0); endfunction
  function automatic bit rb(); return 1'($urandom_range(0, 1)); endfunction

  // Expected control word for one named micro-step
  function automatic logic [30:0] sw(input string s, input bit ir5);
    logic [30:0] w;
    w = 31'd0; w[P_OE] = 1'b1; w[P_WE] = 1'b1; w[P_BUSY] = 1'b1;
    case (s)
      "HALT":   w[P_BUSY] = 1'b0;
      "FETCH":  begin w[P_GPC] = 1'b1; w[P_LDMAR] = 1'b1; w[P_LDPC] = 1'b1; end
      "RD":     w[P_OE] = 1'b0;
      "RDL":    begin w[P_OE] = 1'b0; w[P_LDMDR] = 1'b1; end
      "IR":     begin w[P_GMDR] = 1'b1; w[P_LDIR] = 1'b1; end
      "DECODE": w[P_LDBEN] = 1'b1;
      "ADD", "AND", "NOT": begin
        w[P_SR1 +: 2] = 2'b01; w[P_GALU] = 1'b1; w[P_LDREG] = 1'b1; w[P_LDCC] = 1'b1;
        if (s == "AND") w[P_ALUK +: 2] = 2'b01;
        if (s == "NOT") w[P_ALUK +: 2] = 2'b10; else w[P_SR2] = ir5;
      end
      "BRT":    begin w[P_ADDR1] = 1'b1; w[P_ADDR2 +: 2] = 2'b01; w[P_PCMUX +: 2] = 2'b01; w[P_LDPC] = 1'b1; end
      "JMP", "JSRR": begin
        w[P_SR1 +: 2] = 2'b01; w[P_ADDR2 +: 2] = 2'b11; w[P_PCMUX +: 2] = 2'b01; w[P_LDPC] = 1'b1;
      end
      "JSRL":   begin w[P_GPC] = 1'b1; w[P_DRMUX +: 2] = 2'b10; w[P_LDREG] = 1'b1; end
      "JSR11":  begin w[P_ADDR1] = 1'b1; w[P_PCMUX +: 2] = 2'b01; w[P_LDPC] = 1'b1; end
      "LEA":    begin
        w[P_ADDR1] = 1'b1; w[P_ADDR2 +: 2] = 2'b01; w[P_MARMUX] = 1'b1; w[P_GMARMUX] = 1'b1;
        w[P_LDREG] = 1'b1; w[P_LDCC] = 1'b1;
      end
      "ADDRPC": begin
        w[P_ADDR1] = 1'b1; w[P_ADDR2 +: 2] = 2'b01; w[P_MARMUX] = 1'b1; w[P_GMARMUX] = 1'b1; w[P_LDMAR] = 1'b1;
      end
      "ADDRREG": begin
        w[P_SR1 +: 2] = 2'b01; w[P_ADDR2 +: 2] = 2'b10; w[P_MARMUX] = 1'b1; w[P_GMARMUX] = 1'b1; w[P_LDMAR] = 1'b1;
      end
      "LDIMAR", "STIMAR": begin w[P_GMDR] = 1'b1; w[P_LDMAR] = 1'b1; end
      "LDWB":   begin w[P_GMDR] = 1'b1; w[P_LDREG] = 1'b1; w[P_LDCC] = 1'b1; end
      "STDATA": begin w[P_ALUK +: 2] = 2'b11; w[P_GALU] = 1'b1; w[P_LDMDR] = 1'b1; end
      "WR":     begin w[P_WE] = 1'b0; w[P_GMDR] = 1'b1; end
      "P1", "P2": w[P_LDLED] = 1'b1;
      default:  w = '1;
    endcase
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input string s, input bit ir5, input bit rdy, input bit cont);
    cyc_t e;
    e.w = sw(s, ir5); e.rdy = rdy; e.cont = cont; e.run = rb(); e.nm = s;
    q.push_back(e);
  endtask

  task automatic push_r(input string s, input bit ir5);
    push(s, ir5, rb(), rb());
  endtask

  // One memory access: minimum length, optional ready stall, then the final cycle
  task automatic push_mem(input int d, input bit rd, input int stall);
    int mn;
    string s;
    mn = rd ? rdw(d) + 1 : wrc(d);
    s = rd ? "RD" : "WR";
    for (int i = 0; i < mn - 1; i++) push_r(s, 1'b0);
    if (usr(d)) for (int i = 0; i < stall; i++) push(s, 1'b0, 1'b0, rb());
    push(rd ? "RDL" : "WR", 1'b0, usr(d) ? 1'b1 : rb(), rb());
  endtask

  task automatic gen(input int d, input logic [3:0] op, input bit ir5, input bit ir11,
                     input bit ben, input int stall);
    string adr;
    adr = (op == 4'b0110 || op == 4'b0111) ? "ADDRREG" : "ADDRPC";
    push_r("FETCH", 1'b0); push_mem(d, 1'b1, stall); push_r("IR", 1'b0); push_r("DECODE", 1'b0);
    case (op)
      4'b0001: push_r("ADD", ir5);
      4'b0101: push_r("AND", ir5);
      4'b1001: push_r("NOT", ir5);
      4'b0000: if (ben) push_r("BRT", 1'b0);
      4'b1100: push_r("JMP", 1'b0);
      4'b0100: begin push_r("JSRL", 1'b0); push_r(ir11 ? "JSR11" : "JSRR", 1'b0); end
      4'b1110: push_r("LEA", 1'b0);
      4'b0010, 4'b0110: begin push_r(adr, 1'b0); push_mem(d, 1'b1, stall); push_r("LDWB", 1'b0); end
      4'b1010: begin
        push_r(adr, 1'b0); push_mem(d, 1'b1, stall); push_r("LDIMAR", 1'b0);
        push_mem(d, 1'b1, stall); push_r("LDWB", 1'b0);
      end
      4'b0011, 4'b0111: begin push_r(adr, 1'b0); push_r("STDATA", 1'b0); push_mem(d, 1'b0, stall); end
      4'b1011: begin
        push_r(adr, 1'b0); push_mem(d, 1'b1, stall); push_r("STIMAR", 1'b0);
        push_r("STDATA", 1'b0); push_mem(d, 1'b0, stall);
      end
      default: begin
        push("P1", 1'b0, rb(), 1'b0); push("P1", 1'b0, rb(), 1'b0); push("P1", 1'b0, rb(), 1'b1);
        push("P2", 1'b0, rb(), 1'b1); push("P2", 1'b0, rb(), 1'b1); push("P2", 1'b0, rb(), 1'b0);
      end
    endcase
  endtask

  // Runs one instruction from FETCH; instruction fields change only once FETCH is entered
  task automatic run_instr(input int d, input logic [3:0] op, input bit ir5, input bit ir11,
                           input bit ben, input int stall, input bit stop_wr);
    cyc_t e;
    int i;
    bit stop;
    q.delete();
    gen(d, op, ir5, ir11, ben, stall);
    i = 0; stop = 1'b0;
    while (q.size() > 0 && !stop) begin
      e = q.pop_front();
      @(posedge clk); #1;
      if (i == 0) begin
        if (d == 0) op_a = op; else op_b = op;
        ir5_v[d] = ir5; ir11_v[d] = ir11; ben_v[d] = ben;
      end
      rdy_v[d] = e.rdy; cont_v[d] = e.cont; run_v[d] = e.run;
      @(negedge clk);
      chk(e.nm, {1'b0, (d == 0) ? cw_a : cw_b}, {1'b0, e.w});
      if (stop_wr && e.nm == "WR") stop = 1'b1;
      i++;
    end
    q.delete();
  endtask

  task automatic do_reset(input int d);
    rst_n_v[d] = 1'b0; run_v[d] = 1'b0; cont_v[d] = 1'b0;
    #1;
    chk("reset", {1'b0, (d == 0) ? cw_a : cw_b}, {1'b0, sw("HALT", 1'b0)});
    @(negedge clk); rst_n_v[d] = 1'b1;
    @(negedge clk);
    chk("halted_idle", {1'b0, (d == 0) ? cw_a : cw_b}, {1'b0, sw("HALT", 1'b0)});
  endtask

  function automatic vec_t mkv(input logic [3:0] op, input bit ir5, input bit ir11,
                               input bit ben, input int len, input string nm);
    vec_t v;
    v.op = op; v.ir5 = ir5; v.ir11 = ir11; v.ben = ben; v.len = len; v.nm = nm;
    return v;
  endfunction

  initial begin
    int n;
    bit seen;
    logic [3:0] op;
    rst_n_v = 2'b00; run_v = 2'b00; cont_v = 2'b00; ir5_v = 2'b00; ir11_v = 2'b00;
    ben_v = 2'b00; rdy_v = 2'b00; op_a = 4'd0; op_b = 4'd0;

    // Instruction lengths FETCH..last step, RD_WAIT=1 and WR_CYCLES=2
    tbl[0]  = mkv(4'b0001, 1'b1, 1'b0, 1'b0, 6,  "len_add");
    tbl[1]  = mkv(4'b0101, 1'b0, 1'b0, 1'b0, 6,  "len_and");
    tbl[2]  = mkv(4'b1001, 1'b0, 1'b0, 1'b0, 6,  "len_not");
    tbl[3]  = mkv(4'b0000, 1'b0, 1'b0, 1'b0, 5,  "len_br_nt");
    tbl[4]  = mkv(4'b0000, 1'b0, 1'b0, 1'b1, 6,  "len_br_t");
    tbl[5]  = mkv(4'b1100, 1'b0, 1'b0, 1'b0, 6,  "len_jmp");
    tbl[6]  = mkv(4'b0100, 1'b0, 1'b1, 1'b0, 7,  "len_jsr");
    tbl[7]  = mkv(4'b0100, 1'b0, 1'b0, 1'b0, 7,  "len_jsrr");
    tbl[8]  = mkv(4'b1110, 1'b0, 1'b0, 1'b0, 6,  "len_lea");
    tbl[9]  = mkv(4'b0010, 1'b0, 1'b0, 1'b0, 9,  "len_ld");
    tbl[10] = mkv(4'b0110, 1'b0, 1'b0, 1'b0, 9,  "len_ldr");
    tbl[11] = mkv(4'b1010, 1'b0, 1'b0, 1'b0, 12, "len_ldi");
    tbl[12] = mkv(4'b0011, 1'b0, 1'b0, 1'b0, 9,  "len_st");
    tbl[13] = mkv(4'b0111, 1'b0, 1'b0, 1'b0, 9,  "len_str");
    tbl[14] = mkv(4'b1011, 1'b0, 1'b0, 1'b0, 12, "len_sti");

    do_reset(0);
    do_reset(1);

    run_v[0] = 1'b1;
    @(posedge clk); #1; run_v[0] = 1'b0;
    @(negedge clk);
    chk("start_fetch", {1'b0, cw_a}, {1'b0, sw("FETCH", 1'b0)});
    for (int t = 0; t < 15; t++) begin
      op_a = tbl[t].op; ir5_v[0] = tbl[t].ir5; ir11_v[0] = tbl[t].ir11; ben_v[0] = tbl[t].ben;
      n = 1; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(posedge clk); #1; rdy_v[0] = rb();
        @(negedge clk);
        if (cw_a == sw("FETCH", 1'b0)) seen = 1'b1; else n++;
      end
      chk(tbl[t].nm, n, tbl[t].len);
    end

    do_reset(0);
    run_v[0] = 1'b1;
    run_instr(0, 4'b0001, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_instr(0, 4'b1101, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      run_instr(0, op, rb(), rb(), rb(), 0, 1'b0);
    end

    run_v[1] = 1'b1;
    run_instr(1, 4'b1010, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(1, 4'b0111, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    run_instr(1, 4'b0100, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      op = 4'($urandom_range(0, 15));
      run_instr(1, op, rb(), rb(), rb(), int'($urandom_range(0, 3)), 1'b0);
    end

    run_instr(1, 4'b0111, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    #2;
    do_reset(1);
    run_v[1] = 1'b1;
    run_instr(1, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
